// File: rtl/cronometru_ctrl_if.sv
// cronometru_ctrl_if: buttons, counter values and control/display signals around the stopwatch control
interface cronometru_ctrl_if;
    logic       btn_ss;
    logic       btn_lr;
    logic [5:0] sec_bin;
    logic [5:0] min_bin;
    logic       min_carry;
    logic       pauza;
    logic       clr_cnt;
    logic [5:0] disp_sec;
    logic [5:0] disp_min;
    logic       lap_active;
    logic       ovf;
    logic [1:0] state;
    modport master (
        input  btn_ss, btn_lr, sec_bin, min_bin, min_carry,
        output pauza, clr_cnt, disp_sec, disp_min, lap_active, ovf, state
    );
    modport slave (
        output btn_ss, btn_lr, sec_bin, min_bin, min_carry,
        input  pauza, clr_cnt, disp_sec, disp_min, lap_active, ovf, state
    );
endinterface

// File: rtl/cronometru_ctrl.sv
// cronometru_ctrl: stopwatch FSM turning start/stop and lap/reset buttons into counter and display control
module cronometru_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input logic               clk_out,
    input logic               reset,
    cronometru_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STOP = 2'b10, LAP = 2'b11} state_t;
    state_t st, nxt;
    logic [SYNC_STAGES-1:0] ss_sync, lr_sync, vld;
    logic ss_q, lr_q, car_q, ss_arm, lr_arm;
    logic pauza, clr_cnt, lap_active, ovf;
    logic [5:0] disp_sec, disp_min, lap_sec, lap_min;
    logic ss_top, lr_top, car_e, ss_e, lr_e;
    logic go_run, go_stop, go_lap, go_idle;
    assign ss_top = ss_sync[SYNC_STAGES-1];
    assign lr_top = lr_sync[SYNC_STAGES-1];
    // A button only arms once it has been seen released, so one held through reset gives no event
    always_ff @(posedge clk_out or posedge reset)
        if (reset) begin
            ss_sync <= '0;
            lr_sync <= '0;
            vld     <= '0;
            ss_q    <= 1'b0;
            lr_q    <= 1'b0;
            car_q   <= 1'b0;
            ss_arm  <= 1'b0;
            lr_arm  <= 1'b0;
        end else begin
            ss_sync <= {ss_sync[SYNC_STAGES-2:0], bus.btn_ss};
            lr_sync <= {lr_sync[SYNC_STAGES-2:0], bus.btn_lr};
            vld     <= {vld[SYNC_STAGES-2:0], 1'b1};
            ss_q    <= ss_top;
            lr_q    <= lr_top;
            car_q   <= bus.min_carry;
            ss_arm  <= ss_arm | (vld[SYNC_STAGES-1] & ~ss_top);
            lr_arm  <= lr_arm | (vld[SYNC_STAGES-1] & ~lr_top);
        end
    // Strict priority: a lower event coinciding with a higher one is dropped
    assign car_e = bus.min_carry & ~car_q;
    assign ss_e  = ss_arm & ss_top & ~ss_q & ~car_e;
    assign lr_e  = lr_arm & lr_top & ~lr_q & ~ss_e & ~car_e;
    assign go_stop = (st == RUN || st == LAP) && (car_e || ss_e);
    assign go_run  = (st == IDLE && ss_e) || (st == STOP && ss_e && !ovf) || (st == LAP && lr_e);
    assign go_lap  = st == RUN && lr_e;
    assign go_idle = st == STOP && lr_e;
    assign nxt = go_run ? RUN : go_stop ? STOP : go_lap ? LAP : go_idle ? IDLE : st;
    always_ff @(posedge clk_out or posedge reset)
        if (reset) begin
            st         <= IDLE;
            pauza      <= 1'b1;
            clr_cnt    <= 1'b0;
            lap_active <= 1'b0;
            ovf        <= 1'b0;
            lap_sec    <= '0;
            lap_min    <= '0;
            disp_sec   <= '0;
            disp_min   <= '0;
        end else begin
            st         <= nxt;
            pauza      <= nxt == IDLE || nxt == STOP;
            lap_active <= nxt == LAP;
            clr_cnt    <= go_idle;
            ovf        <= go_idle ? 1'b0 : ovf | (go_stop & car_e);
            lap_sec    <= go_lap ? bus.sec_bin : lap_sec;
            lap_min    <= go_lap ? bus.min_bin : lap_min;
            disp_sec   <= ovf ? 6'd59 : (st == LAP) ? lap_sec : bus.sec_bin;
            disp_min   <= ovf ? 6'd59 : (st == LAP) ? lap_min : bus.min_bin;
        end
    assign bus.state      = st;
    assign bus.pauza      = pauza;
    assign bus.clr_cnt    = clr_cnt;
    assign bus.lap_active = lap_active;
    assign bus.ovf        = ovf;
    assign bus.disp_sec   = disp_sec;
    assign bus.disp_min   = disp_min;
endmodule

// File: tb/tb_cronometru_ctrl.sv
// tb_cronometru_ctrl: directed scenarios against the stopwatch control with a small MM:SS counter model
module tb_cronometru_ctrl;
    logic clk_out = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [5:0] m_sec, m_min, ld_sec, ld_min;
    logic ld_en = 1'b0;
    logic [5:0] s;
    cronometru_ctrl_if b ();
    cronometru_ctrl #(.SYNC_STAGES(2)) dut (.clk_out(clk_out), .reset(reset), .bus(b));
    always #5 clk_out = ~clk_out;
    // Seconds/minutes counters as they sit downstream: cleared by reset or clr_cnt, held by pauza
    always_ff @(posedge clk_out or posedge reset)
        if (reset) begin
            m_sec <= '0;
            m_min <= '0;
        end else if (b.clr_cnt) begin
            m_sec <= '0;
            m_min <= '0;
        end else if (ld_en) begin
            m_sec <= ld_sec;
            m_min <= ld_min;
        end else if (!b.pauza) begin
            m_sec <= (m_sec == 6'd59) ? 6'd0 : m_sec + 6'd1;
            m_min <= (m_sec != 6'd59) ? m_min : (m_min == 6'd59) ? 6'd0 : m_min + 6'd1;
        end
    assign b.sec_bin   = m_sec;
    assign b.min_bin   = m_min;
    assign b.min_carry = m_sec == 6'd59 && m_min == 6'd59 && !b.pauza;

    task automatic tick(input int n);
        repeat (n) @(negedge clk_out);
    endtask

    task automatic test_reset;
        b.btn_ss = 1'b0;
        b.btn_lr = 1'b0;
        tick(2);
        checks++; if (b.state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b want 00", b.state); end
        checks++; if (b.pauza !== 1'b1) begin errors++; $display("FAIL reset_pauza: got %b want 1", b.pauza); end
        checks++; if ({b.clr_cnt, b.lap_active, b.ovf} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {b.clr_cnt, b.lap_active, b.ovf}); end
        checks++; if ({b.disp_min, b.disp_sec} !== 12'd0) begin errors++; $display("FAIL reset_disp: got %0d:%0d want 0:0", b.disp_min, b.disp_sec); end
        reset = 1'b0;
        tick(5);
    endtask

    task automatic test_start;
        b.btn_ss = 1'b1;
        tick(2);
        checks++; if (b.state !== 2'b00 || b.pauza !== 1'b1) begin errors++; $display("FAIL start_early: got state %b pauza %b want 00 1", b.state, b.pauza); end
        tick(1);
        checks++; if (b.state !== 2'b01 || b.pauza !== 1'b0) begin errors++; $display("FAIL start_run: got state %b pauza %b want 01 0", b.state, b.pauza); end
        tick(20);
        checks++; if (b.state !== 2'b01) begin errors++; $display("FAIL start_hold: got %b want 01", b.state); end
        b.btn_ss = 1'b0;
        tick(3);
    endtask

    task automatic test_lap;
        ld_en = 1'b1; ld_sec = 6'd11; ld_min = 6'd0;
        b.btn_lr = 1'b1;
        tick(1);
        ld_en = 1'b0;
        tick(2);
        checks++; if (b.state !== 2'b11 || b.lap_active !== 1'b1 || b.pauza !== 1'b0) begin errors++; $display("FAIL lap_enter: got state %b lap %b pauza %b want 11 1 0", b.state, b.lap_active, b.pauza); end
        tick(2);
        checks++; if (b.sec_bin !== 6'd15) begin errors++; $display("FAIL lap_live: got %0d want 15", b.sec_bin); end
        checks++; if (b.disp_min !== 6'd0 || b.disp_sec !== 6'd12) begin errors++; $display("FAIL lap_disp: got %0d:%0d want 0:12", b.disp_min, b.disp_sec); end
        b.btn_lr = 1'b0;
        tick(3);
        checks++; if (b.disp_sec !== 6'd12) begin errors++; $display("FAIL lap_frozen: got %0d want 12", b.disp_sec); end
        b.btn_lr = 1'b1;
        tick(3);
        checks++; if (b.state !== 2'b01 || b.lap_active !== 1'b0) begin errors++; $display("FAIL lap_release: got state %b lap %b want 01 0", b.state, b.lap_active); end
        tick(1);
        s = b.sec_bin;
        tick(1);
        checks++; if (b.disp_sec !== s || b.sec_bin !== s + 6'd1) begin errors++; $display("FAIL lap_track: got disp %0d live %0d want %0d %0d", b.disp_sec, b.sec_bin, s, s + 6'd1); end
        b.btn_lr = 1'b0;
        tick(3);
    endtask

    task automatic test_stop_clear;
        b.btn_ss = 1'b1;
        tick(3);
        checks++; if (b.state !== 2'b10 || b.pauza !== 1'b1) begin errors++; $display("FAIL stop_enter: got state %b pauza %b want 10 1", b.state, b.pauza); end
        s = b.sec_bin;
        b.btn_ss = 1'b0;
        tick(4);
        checks++; if (b.sec_bin !== s) begin errors++; $display("FAIL stop_frozen: got %0d want %0d", b.sec_bin, s); end
        b.btn_lr = 1'b1;
        tick(3);
        checks++; if (b.state !== 2'b00 || b.clr_cnt !== 1'b1) begin errors++; $display("FAIL clear_pulse: got state %b clr %b want 00 1", b.state, b.clr_cnt); end
        tick(1);
        checks++; if (b.clr_cnt !== 1'b0 || b.sec_bin !== 6'd0 || b.disp_sec !== s) begin errors++; $display("FAIL clear_next: got clr %b cnt %0d disp %0d want 0 0 %0d", b.clr_cnt, b.sec_bin, b.disp_sec, s); end
        tick(1);
        checks++; if (b.disp_min !== 6'd0 || b.disp_sec !== 6'd0) begin errors++; $display("FAIL clear_disp: got %0d:%0d want 0:0", b.disp_min, b.disp_sec); end
        b.btn_lr = 1'b0;
        tick(3);
    endtask

    task automatic test_overflow;
        b.btn_ss = 1'b1;
        tick(3);
        b.btn_ss = 1'b0;
        ld_en = 1'b1; ld_sec = 6'd50; ld_min = 6'd59;
        tick(1);
        ld_en = 1'b0;
        for (int i = 0; i < 30 && b.state !== 2'b10; i++) tick(1);
        checks++; if (b.state !== 2'b10 || b.ovf !== 1'b1 || b.pauza !== 1'b1) begin errors++; $display("FAIL ovf_stop: got state %b ovf %b pauza %b want 10 1 1", b.state, b.ovf, b.pauza); end
        checks++; if (b.disp_min !== 6'd59 || b.disp_sec !== 6'd59) begin errors++; $display("FAIL ovf_disp: got %0d:%0d want 59:59", b.disp_min, b.disp_sec); end
        tick(2);
        checks++; if (b.sec_bin !== 6'd0 || b.disp_min !== 6'd59 || b.disp_sec !== 6'd59) begin errors++; $display("FAIL ovf_hold: got cnt %0d disp %0d:%0d want 0 59:59", b.sec_bin, b.disp_min, b.disp_sec); end
        b.btn_ss = 1'b1;
        tick(5);
        checks++; if (b.state !== 2'b10 || b.pauza !== 1'b1) begin errors++; $display("FAIL ovf_ss_ignored: got state %b pauza %b want 10 1", b.state, b.pauza); end
        b.btn_ss = 1'b0;
        tick(3);
        b.btn_lr = 1'b1;
        tick(3);
        checks++; if (b.state !== 2'b00 || b.ovf !== 1'b0 || b.clr_cnt !== 1'b1) begin errors++; $display("FAIL ovf_clear: got state %b ovf %b clr %b want 00 0 1", b.state, b.ovf, b.clr_cnt); end
        b.btn_lr = 1'b0;
        tick(3);
    endtask

    task automatic test_simul_ss_lr;
        b.btn_ss = 1'b1;
        tick(3);
        b.btn_ss = 1'b0;
        tick(3);
        b.btn_ss = 1'b1;
        b.btn_lr = 1'b1;
        tick(3);
        checks++; if (b.state !== 2'b10 || b.lap_active !== 1'b0) begin errors++; $display("FAIL simul_stop: got state %b lap %b want 10 0", b.state, b.lap_active); end
        tick(3);
        checks++; if (b.state !== 2'b10) begin errors++; $display("FAIL simul_dropped: got %b want 10", b.state); end
        b.btn_ss = 1'b0;
        b.btn_lr = 1'b0;
        tick(3);
        b.btn_lr = 1'b1;
        tick(3);
        b.btn_lr = 1'b0;
        tick(3);
    endtask

    task automatic test_carry_ss_lap;
        b.btn_ss = 1'b1;
        tick(3);
        b.btn_ss = 1'b0;
        b.btn_lr = 1'b1;
        tick(3);
        checks++; if (b.state !== 2'b11) begin errors++; $display("FAIL carry_lap_enter: got %b want 11", b.state); end
        b.btn_lr = 1'b0;
        tick(3);
        // Load lands on 59:58 so the carry cycle coincides with the start/stop event
        ld_en = 1'b1; ld_sec = 6'd58; ld_min = 6'd59;
        b.btn_ss = 1'b1;
        tick(1);
        ld_en = 1'b0;
        tick(2);
        checks++; if (b.state !== 2'b10 || b.ovf !== 1'b1) begin errors++; $display("FAIL carry_beats_ss: got state %b ovf %b want 10 1", b.state, b.ovf); end
        b.btn_ss = 1'b0;
        tick(3);
        b.btn_lr = 1'b1;
        tick(3);
        b.btn_lr = 1'b0;
        tick(3);
    endtask

    task automatic test_reset_mid;
        b.btn_ss = 1'b1;
        tick(3);
        b.btn_ss = 1'b0;
        b.btn_lr = 1'b1;
        tick(5);
        checks++; if (b.state !== 2'b11) begin errors++; $display("FAIL mid_lap: got %b want 11", b.state); end
        reset = 1'b1;
        #1;
        checks++; if (b.state !== 2'b00 || b.pauza !== 1'b1 || b.lap_active !== 1'b0 || b.ovf !== 1'b0 || b.clr_cnt !== 1'b0) begin errors++; $display("FAIL mid_async: got state %b pauza %b lap %b ovf %b clr %b want 00 1 0 0 0", b.state, b.pauza, b.lap_active, b.ovf, b.clr_cnt); end
        checks++; if (b.disp_sec !== 6'd0 || b.disp_min !== 6'd0) begin errors++; $display("FAIL mid_disp: got %0d:%0d want 0:0", b.disp_min, b.disp_sec); end
        b.btn_ss = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(8);
        checks++; if (b.state !== 2'b00) begin errors++; $display("FAIL mid_ss_held: got %b want 00", b.state); end
        b.btn_ss = 1'b0;
        tick(3);
        b.btn_ss = 1'b1;
        tick(3);
        checks++; if (b.state !== 2'b01) begin errors++; $display("FAIL mid_ss_repress: got %b want 01", b.state); end
        b.btn_ss = 1'b0;
        tick(5);
        checks++; if (b.state !== 2'b01) begin errors++; $display("FAIL mid_lr_held: got %b want 01", b.state); end
        b.btn_lr = 1'b0;
        tick(3);
        b.btn_lr = 1'b1;
        tick(3);
        checks++; if (b.state !== 2'b11) begin errors++; $display("FAIL mid_lr_repress: got %b want 11", b.state); end
        b.btn_lr = 1'b0;
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_start();
        test_lap();
        test_stop_clear();
        test_overflow();
        test_simul_ss_lr();
        test_carry_ss_lap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
